// File: rtl/decimal_input_reader.sv
// decimal_input_reader
// Reads a BCD value from the board switches when the operator presses the
// confirm key. The value is converted to binary one digit per cycle and is
// returned to the processor's IN instruction. The processor is stalled through
// 'busy' until the result is ready.
module decimal_input_reader #(
    parameter int DIGITS          = 5,
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  confirm_n,
    input  logic                  read_req,
    output logic [WIDTH-1:0]      data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  digit_error,
    output logic                  waiting
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        CONVERT,
        DONE,
        WAIT_RELEASE
    } state_t;

    state_t              state;
    logic                sync_q1;
    logic                sync_q2;
    logic [DBW-1:0]      db_count;
    logic                key_pressed;
    logic                key_prev;
    logic                key_rise;
    logic [4*DIGITS-1:0] digits_lat;
    logic [WIDTH-1:0]    acc;
    logic [IDXW-1:0]     idx;
    logic                err;
    logic [3:0]          cur_digit;
    logic [WIDTH-1:0]    acc_next;
    logic                err_next;

    // The stall drops in the same cycle that the result is presented.
    assign busy = read_req & ~data_valid;

    // The latched digits are shifted left each cycle, so the digit being
    // converted is always the top nibble. The conversion order is MSD first.
    assign cur_digit = digits_lat[4*DIGITS-1 -: 4];
    assign acc_next  = (acc << 3) + (acc << 1) + WIDTH'(cur_digit);
    assign err_next  = err | (cur_digit > 4'd9);
    assign key_rise  = key_pressed & ~key_prev;

    // Two-flop synchronizer for the asynchronous key. At reset it reads as released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= confirm_n;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: the key changes state only after DEBOUNCE_CYCLES consecutive opposite samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_count    <= '0;
            key_pressed <= 1'b0;
            key_prev    <= 1'b0;
        end else begin
            key_prev <= key_pressed;
            if (~sync_q2 != key_pressed) begin
                if (db_count == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    key_pressed <= ~sync_q2;
                    db_count    <= '0;
                end else begin
                    db_count <= db_count + DBW'(1);
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    // Request/confirm/convert sequencer with registered outputs. The result is
    // loaded on the last conversion step, so it is visible during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_out    <= '0;
            data_valid  <= 1'b0;
            digit_error <= 1'b0;
            waiting     <= 1'b0;
            digits_lat  <= '0;
            acc         <= '0;
            idx         <= '0;
            err         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_req) begin
                        if (key_pressed) begin
                            state <= WAIT_RELEASE;
                        end else begin
                            state   <= WAIT_PRESS;
                            waiting <= 1'b1;
                        end
                    end
                end
                WAIT_PRESS: begin
                    if (!read_req) begin
                        state   <= IDLE;
                        waiting <= 1'b0;
                    end else if (key_rise) begin
                        digits_lat <= digits_in;
                        acc        <= '0;
                        idx        <= IDXW'(DIGITS - 1);
                        err        <= 1'b0;
                        waiting    <= 1'b0;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc        <= acc_next;
                    err        <= err_next;
                    digits_lat <= digits_lat << 4;
                    if (idx == '0) begin
                        data_out    <= err_next ? '0 : acc_next;
                        digit_error <= err_next;
                        data_valid  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                DONE: begin
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!key_pressed) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_input_reader.sv
// Testbench for decimal_input_reader. Expected conversions are queued when a
// key press is driven. They are compared when data_valid pulses.
module tb_decimal_input_reader;

    localparam int DIGITS   = 5;
    localparam int WIDTH    = 32;
    localparam int DEB      = 16;
    // The latency runs from the key going low to data_valid. It includes the
    // 2-flop sync, the debounce count and DIGITS+1 cycles to DONE.
    localparam int LATENCY  = 2 + DEB + DIGITS + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [4*DIGITS-1:0] digits_in;
    logic                confirm_n;
    logic                read_req;
    logic [WIDTH-1:0]    data_out;
    logic                data_valid;
    logic                busy;
    logic                digit_error;
    logic                waiting;

    exp_t sb[$];
    int   errors      = 0;
    int   checks      = 0;
    int   valid_count = 0;

    decimal_input_reader #(
        .DIGITS(DIGITS),
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digits_in(digits_in),
        .confirm_n(confirm_n),
        .read_req(read_req),
        .data_out(data_out),
        .data_valid(data_valid),
        .busy(busy),
        .digit_error(digit_error),
        .waiting(waiting)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExpected(input logic [WIDTH-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Presses the key and waits, with a bound, for the next data_valid.
    // The switches can optionally be changed after change_at cycles.
    task automatic pressAndWait(input int change_at, input logic [4*DIGITS-1:0] change_val,
                                output int lat);
        int start;
        start     = valid_count;
        lat       = 0;
        confirm_n = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == change_at) digits_in = change_val;
            if (valid_count != start) break;
        end
        if (valid_count == start) checkOutput("valid_timeout", 0, 1);
    endtask

    // Runs one full IN transaction. The key can optionally be left held afterwards.
    task automatic applyStimulus(input logic [4*DIGITS-1:0] bcd, input logic [WIDTH-1:0] exp_data,
                                 input logic exp_err, input int change_at,
                                 input logic [4*DIGITS-1:0] change_val, input bit keep_key);
        int lat;
        digits_in = bcd;
        read_req  = 1'b1;
        waitCycles(2);
        checkOutput("waiting_pre_press", waiting, 1);
        checkOutput("busy_pre_press", busy, 1);
        pushExpected(exp_data, exp_err);
        pressAndWait(change_at, change_val, lat);
        checkOutput("latency", lat, LATENCY);
        read_req = 1'b0;
        if (!keep_key) begin
            confirm_n = 1'b1;
            waitCycles(DEB + 6);
        end else begin
            waitCycles(2);
        end
    endtask

    // Scoreboard: every data_valid pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            valid_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("data_out", data_out, e.data);
                checkOutput("digit_error", digit_error, e.err);
                checkOutput("busy_on_valid", busy, 0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int vc;
        rst_n     = 1'b0;
        digits_in = '0;
        confirm_n = 1'b1;
        read_req  = 1'b0;

        // Check the reset values. busy must still follow read_req during reset.
        waitCycles(2);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_data_valid", data_valid, 0);
        checkOutput("rst_digit_error", digit_error, 0);
        checkOutput("rst_waiting", waiting, 0);
        read_req = 1'b1;
        #1;
        checkOutput("rst_busy_follows_req", busy, 1);
        read_req = 1'b0;
        #1;
        checkOutput("rst_busy_idle", busy, 0);
        waitCycles(1);
        rst_n = 1'b1;
        waitCycles(5);

        // Basic conversion, with the latency checked inside applyStimulus
        applyStimulus(20'h12345, 32'd12345, 1'b0, 0, '0, 1'b0);
        checkOutput("hold_after_valid", data_out, 12345);

        // Largest value and zero
        applyStimulus(20'h99999, 32'd99999, 1'b0, 0, '0, 1'b0);
        applyStimulus(20'h00000, 32'd0, 1'b0, 0, '0, 1'b0);

        // An invalid digit forces zero and the error flag. A good entry clears it.
        applyStimulus(20'h1A345, 32'd0, 1'b1, 0, '0, 1'b0);
        checkOutput("error_held", digit_error, 1);
        applyStimulus(20'h00042, 32'd42, 1'b0, 0, '0, 1'b0);
        checkOutput("error_cleared", digit_error, 0);

        // A short key glitch is not accepted. Aborting the request gives no result.
        vc        = valid_count;
        digits_in = 20'h00555;
        read_req  = 1'b1;
        waitCycles(2);
        confirm_n = 1'b0;
        waitCycles(5);
        confirm_n = 1'b1;
        waitCycles(DEB + 10);
        checkOutput("glitch_waiting", waiting, 1);
        checkOutput("glitch_busy", busy, 1);
        checkOutput("glitch_no_valid", valid_count, vc);
        read_req = 1'b0;
        waitCycles(3);
        checkOutput("abort_waiting", waiting, 0);
        checkOutput("abort_no_valid", valid_count, vc);

        // The switches change mid-conversion and the latched value is used.
        // The key stays held through DONE.
        applyStimulus(20'h00314, 32'd314, 1'b0, LATENCY - 4, 20'h99999, 1'b1);
        vc       = valid_count;
        read_req = 1'b1;
        waitCycles(40);
        checkOutput("held_key_no_valid", valid_count, vc);
        checkOutput("held_key_busy", busy, 1);
        checkOutput("held_key_not_waiting", waiting, 0);
        confirm_n = 1'b1;
        waitCycles(DEB + 6);
        checkOutput("after_release_waiting", waiting, 1);
        checkOutput("after_release_no_valid", valid_count, vc);
        pushExpected(32'd99999, 1'b0);
        pressAndWait(0, '0, lat);
        checkOutput("fresh_press_latency", lat, LATENCY);
        read_req  = 1'b0;
        confirm_n = 1'b1;
        waitCycles(DEB + 6);

        // A reset in the middle of CONVERT discards the conversion.
        vc        = valid_count;
        digits_in = 20'h55555;
        read_req  = 1'b1;
        waitCycles(2);
        confirm_n = 1'b0;
        waitCycles(2 + DEB + 3);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_data_out", data_out, 0);
        checkOutput("midrst_data_valid", data_valid, 0);
        checkOutput("midrst_waiting", waiting, 0);
        confirm_n = 1'b1;
        read_req  = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(10);
        checkOutput("midrst_no_valid", valid_count, vc);
        checkOutput("midrst_idle_waiting", waiting, 0);
        applyStimulus(20'h00007, 32'd7, 1'b0, 0, '0, 1'b0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
